// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with row debounce and press strobe
// Optional auto-repeat of key_strobe while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 10,
  parameter int REPEAT_SCANS = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_drive,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_MAX  = BW'(DEBOUNCE_CNT);

  if (SCAN_DIV < 2 || DEBOUNCE_CNT < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scanner: illegal parameter value");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state, state_nx;
  logic [3:0]    rs_meta, rs;
  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx, col_idx_nx;
  logic [3:0]    cap_row, cap_row_nx, cap_col, cap_col_nx;
  logic [BW-1:0] deb_cnt, deb_cnt_nx, deb_inc;
  logic [3:0]    row_nx, col_nx;
  logic          key_valid_nx, key_strobe_nx;
  logic          sample, onehot, accept;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0] rep_cnt, rep_cnt_nx;
`endif

  assign sample    = (div_cnt == DIV_LAST);
  assign onehot    = (rs != 4'd0) && ((rs & (rs - 4'd1)) == 4'd0);
  assign deb_inc   = (deb_cnt == DEB_MAX) ? deb_cnt : deb_cnt + BW'(1);
  assign col_drive = 4'(4'b0001 << col_idx);

  always_comb begin
    state_nx      = state;
    col_idx_nx    = col_idx;
    cap_row_nx    = cap_row;
    cap_col_nx    = cap_col;
    deb_cnt_nx    = deb_cnt;
    row_nx        = row;
    col_nx        = col;
    key_valid_nx  = key_valid;
    key_strobe_nx = 1'b0;
    accept        = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_nx    = rep_cnt;
`endif
    if (sample) begin
      case (state)
        SCAN: begin
          if (onehot) begin
            cap_row_nx = rs;
            cap_col_nx = col_drive;
            deb_cnt_nx = BW'(1);
            if (DEBOUNCE_CNT == 1) accept = 1'b1;
            else state_nx = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rs == cap_row) begin
            deb_cnt_nx = deb_inc;
            if (deb_inc == DEB_MAX) accept = 1'b1;
          end else begin
            deb_cnt_nx = '0;
            state_nx   = SCAN;
            col_idx_nx = col_idx + 2'd1;
          end
        end
        HELD: begin
          if (rs != cap_row) begin
            deb_cnt_nx = '0;
            state_nx   = RELEASE;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            rep_cnt_nx    = '0;
            key_strobe_nx = 1'b1;
          end else begin
            rep_cnt_nx = rep_cnt + RW'(1);
          end
`endif
        end
        RELEASE: begin
          if (rs == 4'd0) begin
            deb_cnt_nx = deb_inc;
            if (deb_inc == DEB_MAX) begin
              deb_cnt_nx   = '0;
              state_nx     = SCAN;
              key_valid_nx = 1'b0;
              row_nx       = 4'd0;
              col_nx       = 4'd0;
              col_idx_nx   = col_idx + 2'd1;
            end
          end else if (rs == cap_row) begin
            // Bounce back to the held key: resume holding without a new strobe.
            deb_cnt_nx = '0;
            state_nx   = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt_nx = '0;
`endif
          end else begin
            deb_cnt_nx = '0;
          end
        end
        default: state_nx = SCAN;
      endcase
    end
    if (accept) begin
      state_nx      = HELD;
      row_nx        = cap_row_nx;
      col_nx        = cap_col_nx;
      key_valid_nx  = 1'b1;
      key_strobe_nx = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_nx    = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_meta    <= 4'd0;
      rs         <= 4'd0;
      div_cnt    <= '0;
      state      <= SCAN;
      col_idx    <= 2'd0;
      cap_row    <= 4'd0;
      cap_col    <= 4'd0;
      deb_cnt    <= '0;
      row        <= 4'd0;
      col        <= 4'd0;
      key_valid  <= 1'b0;
      key_strobe <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      rs_meta    <= row_in;
      rs         <= rs_meta;
      div_cnt    <= sample ? '0 : div_cnt + DW'(1);
      state      <= state_nx;
      col_idx    <= col_idx_nx;
      cap_row    <= cap_row_nx;
      cap_col    <= cap_col_nx;
      deb_cnt    <= deb_cnt_nx;
      row        <= row_nx;
      col        <= col_nx;
      key_valid  <= key_valid_nx;
      key_strobe <= key_strobe_nx;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt    <= rep_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized scoreboard bench for keypad_scanner
module tb_keypad_scanner;
  localparam int SD = 4;
  localparam int DC = 3;
  localparam int RS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_drive, row, col;
  logic       key_valid, key_strobe;
  logic [3:0] keymap [4];

  int n_cmp = 0;
  int n_bad = 0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC), .REPEAT_SCANS(RS)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_drive(col_drive),
    .row(row), .col(col), .key_valid(key_valid), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a driven column shows the rows of its pressed keys.
  always_comb begin
    row_in = 4'd0;
    for (int c = 0; c < 4; c++) if (col_drive[c]) row_in = row_in | keymap[c];
  end

  typedef struct {logic [3:0] r; logic [3:0] c; int t;} exp_t;
  exp_t sb[$];

  // Reference model, advanced once per clock from the row lines it will sample.
  typedef enum {M_SCAN, M_BOUNCE, M_HOLD, M_REL} mode_t;
  mode_t      m_mode;
  logic [3:0] m_rs1, m_rs2, m_cap_r, m_cap_c, m_row, m_col;
  int         m_div, m_ci, m_cnt, m_rep, cyc = 0;
  logic       m_valid;

  task automatic model_reset();
    m_mode = M_SCAN; m_rs1 = 0; m_rs2 = 0; m_cap_r = 0; m_cap_c = 0;
    m_row = 0; m_col = 0; m_div = 0; m_ci = 0; m_cnt = 0; m_rep = 0; m_valid = 0;
  endtask

  task automatic model_accept();
    exp_t e;
    m_mode = M_HOLD; m_row = m_cap_r; m_col = m_cap_c; m_valid = 1; m_rep = 0;
    e.r = m_cap_r; e.c = m_cap_c; e.t = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic model_step();
    logic [3:0] r;
    exp_t e;
    bit samp;
    r = m_rs2;
    samp = (m_div == SD - 1);
    m_rs2 = m_rs1; m_rs1 = row_in;
    m_div = (m_div + 1) % SD;
    if (samp) begin
      case (m_mode)
        M_SCAN:
          if ($countones(r) == 1) begin
            m_cap_r = r; m_cap_c = 4'(1 << m_ci); m_cnt = 1;
            if (m_cnt >= DC) model_accept(); else m_mode = M_BOUNCE;
          end else m_ci = (m_ci + 1) % 4;
        M_BOUNCE:
          if (r == m_cap_r) begin
            m_cnt++;
            if (m_cnt >= DC) model_accept();
          end else begin
            m_cnt = 0; m_mode = M_SCAN; m_ci = (m_ci + 1) % 4;
          end
        M_HOLD:
          if (r != m_cap_r) begin
            m_cnt = 0; m_mode = M_REL;
          end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
            m_rep++;
            if (m_rep == RS) begin
              m_rep = 0; e.r = m_cap_r; e.c = m_cap_c; e.t = cyc + 1;
              sb.push_back(e);
            end
`endif
          end
        M_REL:
          if (r == 0) begin
            m_cnt++;
            if (m_cnt >= DC) begin
              m_mode = M_SCAN; m_cnt = 0; m_valid = 0; m_row = 0; m_col = 0;
              m_ci = (m_ci + 1) % 4;
            end
          end else if (r == m_cap_r) begin
            m_mode = M_HOLD; m_rep = 0;
          end else m_cnt = 0;
      endcase
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    n_cmp++;
    if ({col_drive, row, col, key_valid} !== {4'(1 << m_ci), m_row, m_col, m_valid}) begin
      n_bad++;
      $display("FAIL state @%0d: got col_drive=%b row=%b col=%b valid=%b, expected %b %b %b %b",
               cyc, col_drive, row, col, key_valid, 4'(1 << m_ci), m_row, m_col, m_valid);
    end
    if (rst_n) model_step();
    cyc++;
  end

  // Monitor: every strobe must match the oldest expected press/repeat.
  int mcyc = 0;
  always @(negedge clk) begin
    if (key_strobe) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL strobe_extra @%0d: got row=%b col=%b, expected no strobe", mcyc, row, col);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (row !== e.r || col !== e.c || mcyc != e.t || key_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL strobe: got row=%b col=%b t=%0d valid=%b, expected row=%b col=%b t=%0d valid=1",
                   row, col, mcyc, key_valid, e.r, e.c, e.t);
        end
      end
    end
    mcyc++;
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_keys();
    for (int c = 0; c < 4; c++) keymap[c] = 4'd0;
  endtask

  initial begin
    clear_keys();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    // clean press row 0010 on column 2, then release
    keymap[2] = 4'b0010; tick(80); clear_keys(); tick(60);
    // short bounces, then a clean hold
    keymap[1] = 4'b0001; tick(5); clear_keys(); tick(3);
    keymap[1] = 4'b0001; tick(6); clear_keys(); tick(20);
    keymap[1] = 4'b0001; tick(70); clear_keys(); tick(60);
    // two rows on one column are never accepted
    keymap[0] = 4'b0101; tick(60); clear_keys(); tick(20);
    // release bounce back to the held key
    keymap[2] = 4'b0010; tick(60); clear_keys(); tick(9);
    keymap[2] = 4'b0010; tick(4); clear_keys(); tick(60);
    keymap[2] = 4'b0010; tick(60);
    // asynchronous reset while held
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({col_drive, row, col, key_valid, key_strobe} !== {4'b0001, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got %b %b %b %b %b, expected 0001 0000 0000 0 0",
               col_drive, row, col, key_valid, key_strobe);
    end
    clear_keys();
    tick(3);
    rst_n = 1'b1;
    tick(20);
    // randomized presses, multi-key and cross-column noise
    for (int i = 0; i < 40; i++) begin
      int c;
      c = $urandom_range(0, 3);
      keymap[c] = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) keymap[c] = keymap[c] | 4'(1 << $urandom_range(0, 3));
      tick($urandom_range(1, 40));
      if ($urandom_range(0, 3) == 0) keymap[(c + 1) % 4] = 4'(1 << $urandom_range(0, 3));
      tick($urandom_range(1, 40));
      clear_keys();
      tick($urandom_range(1, 50));
    end
    clear_keys();
    tick(100);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL strobe_missing: got %0d pending expected strobes, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
